// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and sizing helper for the neuron MAC
// Contents:
//   act_mode_e  - activation selection (ACT_NONE, ACT_RELU)
//   state_e     - inference sequencer states
//   acc_width() - accumulator width wide enough that no partial sum can overflow
package neuron_pkg;

    typedef enum logic {
        ACT_NONE = 1'b0,
        ACT_RELU = 1'b1
    } act_mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACCUM = 3'd1,
        BIAS  = 3'd2,
        ACT   = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Full product width plus one growth bit per doubling of the pair count,
    // plus one spare bit so the bias addition cannot overflow either.
    function automatic int acc_width(input int data_w, input int n_in);
        return 2 * data_w + $clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/neuron_act.sv
// rtl/neuron_act.sv - fixed-point rescale, saturation and activation
// Ports:
//   acc - signed accumulator holding the biased sum with 2*FRAC_W fraction bits
//   z   - DATA_W result with FRAC_W fraction bits, saturated, activation applied
module neuron_act
    import neuron_pkg::*;
#(
    parameter int        DATA_W   = 16,
    parameter int        FRAC_W   = 8,
    parameter int        ACC_W    = 41,
    parameter act_mode_e ACT_MODE = ACT_RELU
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic        [DATA_W-1:0] z
);

    logic signed [ACC_W-1:0]  shifted;
    logic        [ACC_W-DATA_W:0] hi;
    logic        [DATA_W-1:0] sat;

    always_comb begin
        // Arithmetic shift drops the extra fraction bits, rounding toward -inf.
        shifted = acc >>> FRAC_W;
        // The value fits in DATA_W iff every bit from the DATA_W sign bit
        // upwards agrees; otherwise clamp by the true sign.
        hi = shifted[ACC_W-1:DATA_W-1];
        if ((&hi) || (~|hi)) begin
            sat = shifted[DATA_W-1:0];
        end else if (hi[ACC_W-DATA_W]) begin
            sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat = {1'b0, {(DATA_W-1){1'b1}}};
        end

        if ((ACT_MODE == ACT_RELU) && sat[DATA_W-1]) begin
            z = '0;
        end else begin
            z = sat;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - single neuron multiply-accumulate with bias and activation
// Ports:
//   Clk, Reset          - clock, asynchronous active-high reset
//   Start, Bias         - begin an inference; Bias captured with Start in IDLE
//   In_valid, In_ready  - X/W pair handshake, ready only while accumulating
//   X, W                - signed fixed-point activation and weight
//   Busy                - sequencer is not idle
//   Out_valid, Out_ready, Z - result handshake; Z held until taken and after
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int        N_IN     = 784,
    parameter int        DATA_W   = 16,
    parameter int        FRAC_W   = 8,
    parameter act_mode_e ACT_MODE = ACT_RELU
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [DATA_W-1:0] Bias,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [DATA_W-1:0] X,
    input  logic [DATA_W-1:0] W,
    output logic              Busy,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [DATA_W-1:0] Z
);

    localparam int ACC_W = acc_width(DATA_W, N_IN);
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic        [DATA_W-1:0] bias_q, bias_d;
    logic        [DATA_W-1:0] z_q, z_d;
    logic        [DATA_W-1:0] act_z;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;

    assign prod     = $signed(X) * $signed(W);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    // Bias carries FRAC_W fraction bits while products carry 2*FRAC_W, so
    // align it before adding.
    assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias_q[DATA_W-1]}}, bias_q, {FRAC_W{1'b0}}};

    neuron_act #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .ACC_W    (ACC_W),
        .ACT_MODE (ACT_MODE)
    ) u_act (
        .acc (acc_q),
        .z   (act_z)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bias_d  = bias_q;
        z_d     = z_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    bias_d  = Bias;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (In_valid) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = BIAS;
                    end
                end
            end
            BIAS: begin
                acc_d   = acc_q + bias_ext;
                state_d = ACT;
            end
            ACT: begin
                z_d     = act_z;
                state_d = DONE;
            end
            DONE: begin
                if (Out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            bias_q  <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
            z_q     <= z_d;
        end
    end

    assign In_ready  = (state_q == ACCUM);
    assign Busy      = (state_q != IDLE);
    assign Out_valid = (state_q == DONE);
    assign Z         = z_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - self-checking bench for neuron_mac
module tb_neuron_mac;
    import neuron_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] bias = '0;
    logic        in_valid = 1'b0;
    logic        in_valid1 = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] w = '0;
    logic        out_ready = 1'b0;

    logic        rdy_r, busy_r, ov_r;
    logic [15:0] z_r;
    logic        rdy_n, busy_n, ov_n;
    logic [15:0] z_n;
    logic        rdy_1, busy_1, ov_1;
    logic [15:0] z_1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] xa [4];
    logic [15:0] wa [4];

    always #5 clk = ~clk;

    neuron_mac #(.N_IN(4), .DATA_W(16), .FRAC_W(8), .ACT_MODE(ACT_RELU)) dut_relu (
        .Clk(clk), .Reset(rst), .Start(start), .Bias(bias),
        .In_valid(in_valid), .In_ready(rdy_r), .X(x), .W(w),
        .Busy(busy_r), .Out_valid(ov_r), .Out_ready(out_ready), .Z(z_r)
    );

    neuron_mac #(.N_IN(4), .DATA_W(16), .FRAC_W(8), .ACT_MODE(ACT_NONE)) dut_none (
        .Clk(clk), .Reset(rst), .Start(start), .Bias(bias),
        .In_valid(in_valid), .In_ready(rdy_n), .X(x), .W(w),
        .Busy(busy_n), .Out_valid(ov_n), .Out_ready(out_ready), .Z(z_n)
    );

    neuron_mac #(.N_IN(1), .DATA_W(16), .FRAC_W(8), .ACT_MODE(ACT_RELU)) dut_one (
        .Clk(clk), .Reset(rst), .Start(start1), .Bias(bias),
        .In_valid(in_valid1), .In_ready(rdy_1), .X(x), .W(w),
        .Busy(busy_1), .Out_valid(ov_1), .Out_ready(out_ready), .Z(z_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer dot product, bias scaled to product fraction,
    // floor-divide by 2^8, clamp to int16, optional ReLU.
    function automatic logic [15:0] model(input int n, input logic [15:0] xs [4],
                                          input logic [15:0] ws [4], input logic [15:0] b,
                                          input bit relu);
        longint acc = 0;
        for (int i = 0; i < n; i++) begin
            acc += longint'($signed(xs[i])) * longint'($signed(ws[i]));
        end
        acc += longint'($signed(b)) * 256;
        acc = acc >>> 8;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        if (relu && acc < 0) acc = 0;
        return acc[15:0];
    endfunction

    function automatic logic [15:0] small16();
        logic [11:0] t;
        t = 12'($urandom);
        return {{4{t[11]}}, t};
    endfunction

    // Entered and left at posedge+1. vlen>0 selects a fixed In_valid pattern,
    // otherwise In_valid is random. Cycles after the accepting edge are
    // numbered from 1; Out_valid must first be seen in cycle 3.
    task automatic run4(input int id, input logic [15:0] b, input logic [31:0] vpat,
                        input int vlen, input int hold, input bit sid,
                        input logic [15:0] er, input logic [15:0] en);
        int idx = 0;
        int cyc = 0;
        bit v;
        start = 1'b1;
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < 4 && cyc < 200) begin
            v = (vlen > 0 && cyc < vlen) ? vpat[cyc] : 1'($urandom_range(0, 1));
            in_valid = v;
            x = xa[idx];
            w = wa[idx];
            @(negedge clk);
            check($sformatf("t%0d_in_ready_relu", id), rdy_r, 1);
            check($sformatf("t%0d_in_ready_none", id), rdy_n, 1);
            @(posedge clk);
            if (v) idx++;
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check($sformatf("t%0d_accum_done", id), (idx == 4), 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("t%0d_ov_c%0d", id, k), ov_r, (k == 3));
            check($sformatf("t%0d_ov_none_c%0d", id, k), ov_n, (k == 3));
            if (k < 3) check($sformatf("t%0d_in_ready_off_c%0d", id, k), rdy_r, 0);
        end
        check($sformatf("t%0d_z_relu", id), z_r, er);
        check($sformatf("t%0d_z_none", id), z_n, en);
        @(posedge clk); #1;
        for (int h = 0; h < hold; h++) begin
            start = sid;
            @(negedge clk);
            check($sformatf("t%0d_hold_ov", id), ov_r, 1);
            check($sformatf("t%0d_hold_z_relu", id), z_r, er);
            check($sformatf("t%0d_hold_z_none", id), z_n, en);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        start     = sid;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        check($sformatf("t%0d_ov_after", id), ov_r, 0);
        check($sformatf("t%0d_busy_after", id), busy_r, 0);
        check($sformatf("t%0d_busy_none_after", id), busy_n, 0);
        check($sformatf("t%0d_z_kept", id), z_r, er);
        @(posedge clk); #1;
    endtask

    task automatic run1(input int id, input logic [15:0] xv, input logic [15:0] wv,
                        input logic [15:0] b, input logic [15:0] exp);
        start1 = 1'b1;
        bias   = b;
        @(posedge clk); #1;
        start1    = 1'b0;
        in_valid1 = 1'b1;
        x = xv;
        w = wv;
        @(negedge clk);
        check($sformatf("n1_%0d_in_ready", id), rdy_1, 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("n1_%0d_ov_c%0d", id, k), ov_1, (k == 3));
        end
        check($sformatf("n1_%0d_z", id), z_1, exp);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check($sformatf("n1_%0d_idle", id), busy_1, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] b;
        logic [15:0] xo [4];
        logic [15:0] wo [4];

        @(negedge clk);
        check("reset_in_ready", rdy_r, 0);
        check("reset_busy", busy_r, 0);
        check("reset_ov", ov_r, 0);
        check("reset_z", z_r, 0);
        check("reset_busy_one", busy_1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Unit weights at half scale plus unit bias
        xa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        wa = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        run4(1, 16'h0100, 32'hF, 4, 0, 1'b0, 16'h0300, 16'h0300);

        // Negative sum: ReLU clamps, linear passes -4.0
        wa = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        run4(2, 16'h0000, 32'hF, 4, 1, 1'b0, 16'h0000, 16'hFC00);

        // Positive and negative saturation
        xa = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        wa = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run4(3, 16'h7FFF, 32'hF, 4, 0, 1'b0, 16'h7FFF, 16'h7FFF);
        wa = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        run4(4, 16'h0000, 32'hF, 4, 0, 1'b0, 16'h0000, 16'h8000);

        // Gappy In_valid, long stall on Out_ready, Start pressed during DONE
        xa = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        wa = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        run4(5, 16'h0100, 32'b1011001, 7, 5, 1'b1, 16'h0300, 16'h0300);

        // Reset mid-accumulation
        xo = xa;
        wo = wa;
        xa = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
        wa = xa;
        start = 1'b1;
        bias  = 16'h1234;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        x = xa[0];
        w = wa[0];
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", rdy_r, 0);
        check("rst_busy", busy_r, 0);
        check("rst_ov", ov_r, 0);
        check("rst_z", z_r, 0);
        check("rst_z_none", z_n, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xa = xo;
        wa = wo;
        run4(6, 16'h0100, 32'hF, 4, 0, 1'b0, 16'h0300, 16'h0300);

        // Randomised inferences against the reference model
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 4; i++) begin
                xa[i] = (t < 4) ? small16() : 16'($urandom);
                wa[i] = (t < 4) ? small16() : 16'($urandom);
            end
            b = (t < 4) ? small16() : 16'($urandom);
            run4(10 + t, b, 32'h0, 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 model(4, xa, wa, b, 1'b1), model(4, xa, wa, b, 1'b0));
        end

        // Single-pair configuration
        xa = '{16'h0200, 16'h0000, 16'h0000, 16'h0000};
        wa = '{16'h0180, 16'h0000, 16'h0000, 16'h0000};
        run1(0, 16'h0200, 16'h0180, 16'hFF00, 16'h0200);
        for (int t = 1; t < 5; t++) begin
            xa[0] = small16();
            wa[0] = small16();
            b = small16();
            run1(t, xa[0], wa[0], b, model(1, xa, wa, b, 1'b1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
